// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the bit-serial adder.
//               FSM state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  // Default operand width in bits
  localparam int DEFAULT_WIDTH = 8;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_seq_fa_2ha.sv
// ============================================================================
// Module      : fa_2ha
// Description : 1-bit full adder made of two half-adder stages. The carries
//               of the two stages are ORed; they can never both be set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_2ha (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic w_ha1_sum;
  logic w_ha1_carry;
  logic w_ha2_carry;

  // First half adder: operand bits
  assign w_ha1_sum   = a_i ^ b_i;
  assign w_ha1_carry = a_i & b_i;

  // Second half adder: partial sum plus incoming carry
  assign sum_o       = w_ha1_sum ^ cin_i;
  assign w_ha2_carry = w_ha1_sum & cin_i;

  // Carry-out
  assign cout_o      = w_ha1_carry | w_ha2_carry;

endmodule

`default_nettype wire

// File: rtl/serial_add_seq.sv
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial adder. Operands are captured on an accepted start
//               and added LSB first, one bit per clock, through a single
//               shared full adder. done pulses for one cycle when the result
//               is ready; sum/cout then hold until the next accepted start.
//               Optional macro SERIAL_ADD_CIN_EN adds a carry-in port cin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is one bit wider than needed to index WIDTH-1 so that reaching
  // WIDTH after the last bit never wraps.
  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_carry_init;
  logic               w_accept;

`ifdef SERIAL_ADD_CIN_EN
  assign w_carry_init = cin;
`else
  assign w_carry_init = 1'b0;
`endif

  // Start is honoured everywhere except while an addition is running
  assign w_accept = start && (state_q != RUN);

  // The single shared full adder works on the current LSBs
  fa_2ha u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (w_fa_sum),
    .cout_o (w_fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_d = w_fa_sum;
  end else begin : g_sum_wn
    assign sum_d = {w_fa_sum, sum_q[WIDTH-1:1]};
  end

  // Controller: state, counter, operand/result shift registers and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= w_fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
            cout_q  <= w_fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE behave alike: accept a start or rest in IDLE
          if (w_accept) begin
            state_q <= RUN;
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= w_carry_init;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire
